// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// The optional overflow output is enabled by SERIAL_ADDER_OVF_EN.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned digit_count(input int unsigned width, input int unsigned digit_w);
    return width / digit_w;
  endfunction

  // At least one counter bit so N == 1 still has a legal register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT_W-bit adder slice used once per cycle by serial_adder.
// With SERIAL_ADDER_OVF_EN it also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
  output logic               cmsb,
`endif
  output logic               cout
);

  logic [DIGIT_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  assign s     = total[DIGIT_W-1:0];
  assign cout  = total[DIGIT_W];

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the top bit recovered from the top sum bit and its operand bits.
  assign cmsb = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b[DIGIT_W-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin computed DIGIT_W bits per clock with one carry flop.
// Defining SERIAL_ADDER_OVF_EN adds the two's-complement overflow output.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned N     = digit_count(WIDTH, DIGIT_W);
  localparam int unsigned CNT_W = cnt_width(N);

  if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT_W");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_c;
  logic               last_digit;

`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
  logic               dig_cmsb;
`endif

  digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
`ifdef SERIAL_ADDER_OVF_EN
    .cmsb (dig_cmsb),
`endif
    .cout (dig_c)
  );

  assign last_digit = (cnt_q == CNT_W'(N - 1));

  // Select the operand digit addressed by the counter.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        dig_a = a_q[i*DIGIT_W +: DIGIT_W];
        dig_b = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CNT_W'(i)) sum_d[i*DIGIT_W +: DIGIT_W] = dig_s;
        end
        carry_d = dig_c;
        if (last_digit) begin
          cout_d  = dig_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = dig_cmsb ^ dig_c;
`endif
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three configurations (8x1, 8x4, 4x2) share clock and reset.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]      tb_in_valid, tb_out_ready, tb_cin;
  logic [2:0][7:0] tb_a, tb_b;
  logic [2:0]      tb_in_ready, tb_out_valid, tb_cout, tb_ovf;
  logic [2:0][7:0] tb_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if0 ();
  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(4)) if2 ();

  assign if0.in_valid  = tb_in_valid[0];
  assign if0.a         = tb_a[0];
  assign if0.b         = tb_b[0];
  assign if0.cin       = tb_cin[0];
  assign if0.out_ready = tb_out_ready[0];
  assign tb_in_ready[0]  = if0.in_ready;
  assign tb_out_valid[0] = if0.out_valid;
  assign tb_sum[0]       = if0.sum;
  assign tb_cout[0]      = if0.cout;

  assign if1.in_valid  = tb_in_valid[1];
  assign if1.a         = tb_a[1];
  assign if1.b         = tb_b[1];
  assign if1.cin       = tb_cin[1];
  assign if1.out_ready = tb_out_ready[1];
  assign tb_in_ready[1]  = if1.in_ready;
  assign tb_out_valid[1] = if1.out_valid;
  assign tb_sum[1]       = if1.sum;
  assign tb_cout[1]      = if1.cout;

  assign if2.in_valid  = tb_in_valid[2];
  assign if2.a         = tb_a[2][3:0];
  assign if2.b         = tb_b[2][3:0];
  assign if2.cin       = tb_cin[2];
  assign if2.out_ready = tb_out_ready[2];
  assign tb_in_ready[2]  = if2.in_ready;
  assign tb_out_valid[2] = if2.out_valid;
  assign tb_sum[2]       = {4'b0000, if2.sum};
  assign tb_cout[2]      = if2.cout;

`ifdef SERIAL_ADDER_OVF_EN
  assign tb_ovf[0] = if0.ovf;
  assign tb_ovf[1] = if1.ovf;
  assign tb_ovf[2] = if2.ovf;
`else
  assign tb_ovf = 3'b000;
`endif

  serial_adder #(.WIDTH(8), .DIGIT_W(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(8), .DIGIT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(4), .DIGIT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input int sel);
    check({name, " in_ready"}, 32'(tb_in_ready[sel]), 32'd1);
    check({name, " out_valid"}, 32'(tb_out_valid[sel]), 32'd0);
    check({name, " sum"}, 32'(tb_sum[sel]), 32'd0);
    check({name, " cout"}, 32'(tb_cout[sel]), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({name, " ovf"}, 32'(tb_ovf[sel]), 32'd0);
`endif
  endtask

  // One transaction on DUT sel; noise scrambles inputs while the result is pending,
  // hold keeps out_ready low in DONE, chk_hold checks the held outputs and the return to IDLE.
  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input bit noise, input int hold, input bit chk_hold,
                       output logic [7:0] s, output logic co, output logic ov, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!tb_in_ready[sel] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready wait", 32'(tb_in_ready[sel]), 32'd1);
    tb_in_valid[sel] = 1'b1;
    tb_a[sel]        = a;
    tb_b[sel]        = b;
    tb_cin[sel]      = cin;
    @(posedge clk);
    @(negedge clk);
    tb_in_valid[sel] = 1'b0;
    lat = 0;
    while (!tb_out_valid[sel] && lat < 64) begin
      if (noise) begin
        tb_in_valid[sel]  = 1'($urandom_range(0, 1));
        tb_a[sel]         = 8'($urandom);
        tb_b[sel]         = 8'($urandom);
        tb_cin[sel]       = 1'($urandom_range(0, 1));
        tb_out_ready[sel] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    tb_in_valid[sel]  = 1'b0;
    tb_out_ready[sel] = 1'b0;
    s  = tb_sum[sel];
    co = tb_cout[sel];
    ov = tb_ovf[sel];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (chk_hold) begin
        check("hold out_valid", 32'(tb_out_valid[sel]), 32'd1);
        check("hold in_ready", 32'(tb_in_ready[sel]), 32'd0);
        check("hold sum", 32'(tb_sum[sel]), 32'(s));
        check("hold cout", 32'(tb_cout[sel]), 32'(co));
      end
    end
    tb_out_ready[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_out_ready[sel] = 1'b0;
    if (chk_hold) begin
      check("post out_valid", 32'(tb_out_valid[sel]), 32'd0);
      check("post in_ready", 32'(tb_in_ready[sel]), 32'd1);
    end
  endtask

  vec_t       vecs [9];
  int         n_exp [3];
  logic [7:0] r_s;
  logic       r_co, r_ov;
  int         r_lat;

  initial begin
    vecs = '{
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1},
      '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
      '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1}
    };
    n_exp = '{8, 2, 2};

    rst_n        = 1'b0;
    tb_in_valid  = '0;
    tb_out_ready = '0;
    tb_cin       = '0;
    tb_a         = '0;
    tb_b         = '0;

    #3;
    for (int d = 0; d < 3; d++) check_idle($sformatf("reset dut%0d", d), d);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle($sformatf("released dut%0d", d), d);

    // Directed table on the two 8-bit configurations.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        issue(d, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, 1'b0, r_s, r_co, r_ov, r_lat);
        check($sformatf("vec%0d dut%0d sum", i, d), 32'(r_s), 32'(vecs[i].s));
        check($sformatf("vec%0d dut%0d cout", i, d), 32'(r_co), 32'(vecs[i].co));
        check($sformatf("vec%0d dut%0d latency", i, d), 32'(r_lat), 32'(n_exp[d]));
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("vec%0d dut%0d ovf", i, d), 32'(r_ov), 32'(vecs[i].ov));
`endif
      end
    end

    // Backpressure: five cycles stalled in DONE.
    issue(0, 8'hC3, 8'h1E, 1'b1, 1'b0, 5, 1'b1, r_s, r_co, r_ov, r_lat);
    check("backpressure sum", 32'(r_s), 32'h00E2);
    check("backpressure cout", 32'(r_co), 32'd0);

    // Inputs and out_ready scrambled while the result is pending.
    issue(0, 8'h12, 8'h34, 1'b0, 1'b1, 0, 1'b1, r_s, r_co, r_ov, r_lat);
    check("noise sum", 32'(r_s), 32'h0046);
    check("noise latency", 32'(r_lat), 32'd8);
    issue(1, 8'h9C, 8'h88, 1'b1, 1'b1, 2, 1'b1, r_s, r_co, r_ov, r_lat);
    check("noise4 sum", 32'(r_s), 32'h0025);
    check("noise4 cout", 32'(r_co), 32'd1);

    // Asynchronous reset three digits into a RUN.
    @(negedge clk);
    tb_in_valid[0] = 1'b1;
    tb_a[0]        = 8'h55;
    tb_b[0]        = 8'h0F;
    tb_cin[0]      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tb_in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset sum", 32'(tb_sum[0]), 32'h0004);
    rst_n = 1'b0;
    #1;
    check_idle("midrun reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b1, r_s, r_co, r_ov, r_lat);
    check("after reset sum", 32'(r_s), 32'h0046);
    check("after reset cout", 32'(r_co), 32'd0);

    // Exhaustive 4-bit operands with random stall lengths.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp5;
          logic       exp_ov;
          exp5   = 5'(a) + 5'(b) + 5'(c);
          exp_ov = (a[3] == b[3]) && (exp5[3] != a[3]);
          issue(2, 8'(a), 8'(b), 1'(c), 1'b0, int'($urandom_range(0, 3)), 1'b0,
                r_s, r_co, r_ov, r_lat);
          check($sformatf("exh %0d+%0d+%0d", a, b, c), 32'({r_co, r_s[3:0]}), 32'(exp5));
          check($sformatf("exh lat %0d+%0d+%0d", a, b, c), 32'(r_lat), 32'd2);
`ifdef SERIAL_ADDER_OVF_EN
          check($sformatf("exh ovf %0d+%0d+%0d", a, b, c), 32'(r_ov), 32'(exp_ov));
`else
          if (exp_ov && r_ov) check("ovf tied low", 32'(r_ov), 32'd0);
`endif
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
